// File: rtl/activation_stream.sv
// rtl/activation_stream.sv - two-stage multi-lane fixed-point activation pipeline
//
// Purpose: applies one activation function (Step, hard Sigmoid, hard Tanh,
// ReLU, optional LeakyReLU, identity) to LANES signed fixed-point lanes per
// beat, with valid/ready flow control on both sides and an accepted-beat
// counter.
//
// Parameters:
//   LANES  number of parallel lanes (1..16)
//   W      signed lane width in bits (8..32)
//   FRAC   fractional bits per lane (1..W-2), ONE = 1 << FRAC
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-high reset
//   in_valid   input beat present
//   in_ready   input beat accepted when in_valid && in_ready
//   in_act     activation code: 0 Step, 1 Sigmoid, 2 Tanh, 3 ReLU,
//              4 LeakyReLU (identity when disabled), 5-7 identity
//   in_data    lane k at bits [k*W +: W], two's complement
//   out_valid  output beat present
//   out_ready  downstream accepts when out_valid && out_ready
//   out_data   activated lanes, same packing as in_data
//   count_clr  synchronous clear of out_count (wins over an accepted beat)
//   out_count  number of output beats accepted, wraps at 16 bits
//
// Build option: define ACTIVATION_STREAM_LEAKY_RELU_EN to make code 4 a
// LeakyReLU (negative inputs scaled by 1/8 with an arithmetic shift).

module activation_stream #(
    parameter int LANES = 4,
    parameter int W     = 16,
    parameter int FRAC  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_act,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    input  logic               count_clr,
    output logic [15:0]        out_count
);

    // Two guard bits keep every intermediate (2*ONE, x + ONE/2) free of wrap.
    localparam int XW = W + 2;

    localparam logic signed [XW-1:0] ZERO_X    = '0;
    localparam logic signed [XW-1:0] ONE_X     = XW'(1) << FRAC;
    localparam logic signed [XW-1:0] HALF_X    = ONE_X >>> 1;
    localparam logic signed [XW-1:0] TWO_X     = ONE_X <<< 1;
    localparam logic signed [XW-1:0] NEG_ONE_X = -ONE_X;
    localparam logic signed [XW-1:0] NEG_TWO_X = -TWO_X;
    localparam logic signed [XW-1:0] MAX_X     = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_X     = {3'b111, {(W-1){1'b0}}};

    localparam logic [2:0] ACT_STEP    = 3'd0;
    localparam logic [2:0] ACT_SIGMOID = 3'd1;
    localparam logic [2:0] ACT_TANH    = 3'd2;
    localparam logic [2:0] ACT_RELU    = 3'd3;
    localparam logic [2:0] ACT_LEAKY   = 3'd4;

    // ---------------------------------------------------------------
    // Flow control
    // ---------------------------------------------------------------
    logic s1_valid;
    logic s2_advance;
    logic s1_load;

    // Output register can take a new value when empty or being drained.
    assign s2_advance = !out_valid || out_ready;
    // Depends only on registered state and out_ready, never on in_valid.
    assign in_ready   = !s1_valid || s2_advance;
    assign s1_load    = in_valid && in_ready;

    // ---------------------------------------------------------------
    // Stage 1: operand capture plus region flags
    // ---------------------------------------------------------------
    logic [LANES*W-1:0] s1_data;
    logic [2:0]         s1_act;
    logic [LANES-1:0]   s1_gt0, s1_ge1, s1_le_m1, s1_ge2, s1_le_m2;
    logic [LANES-1:0]   f_gt0, f_ge1, f_le_m1, f_ge2, f_le_m2;

    always_comb begin : flag_calc
        logic signed [XW-1:0] x;
        x       = '0;
        f_gt0   = '0;
        f_ge1   = '0;
        f_le_m1 = '0;
        f_ge2   = '0;
        f_le_m2 = '0;
        for (int k = 0; k < LANES; k++) begin
            x          = {{2{in_data[k*W+W-1]}}, in_data[k*W +: W]};
            f_gt0[k]   = x >  ZERO_X;
            f_ge1[k]   = x >= ONE_X;
            f_le_m1[k] = x <= NEG_ONE_X;
            f_ge2[k]   = x >= TWO_X;
            f_le_m2[k] = x <= NEG_TWO_X;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_act   <= '0;
            s1_gt0   <= '0;
            s1_ge1   <= '0;
            s1_le_m1 <= '0;
            s1_ge2   <= '0;
            s1_le_m2 <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (s1_load) begin
                s1_data  <= in_data;
                s1_act   <= in_act;
                s1_gt0   <= f_gt0;
                s1_ge1   <= f_ge1;
                s1_le_m1 <= f_le_m1;
                s1_ge2   <= f_ge2;
                s1_le_m2 <= f_le_m2;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: activation and saturation
    // ---------------------------------------------------------------
    logic [LANES*W-1:0] act_res;

    always_comb begin : act_calc
        logic signed [XW-1:0] x;
        logic signed [XW-1:0] t;
        logic signed [XW-1:0] y;
        x       = '0;
        t       = '0;
        y       = '0;
        act_res = '0;
        for (int k = 0; k < LANES; k++) begin
            x = {{2{s1_data[k*W+W-1]}}, s1_data[k*W +: W]};
            t = (x >>> 2) + HALF_X;
            case (s1_act)
                ACT_STEP: y = s1_gt0[k] ? ONE_X : ZERO_X;
                ACT_SIGMOID: begin
                    if (s1_ge2[k])        y = ONE_X;
                    else if (s1_le_m2[k]) y = ZERO_X;
                    else if (t < ZERO_X)  y = ZERO_X;
                    else if (t > ONE_X)   y = ONE_X;
                    else                  y = t;
                end
                ACT_TANH: begin
                    if (s1_ge1[k])        y = ONE_X;
                    else if (s1_le_m1[k]) y = NEG_ONE_X;
                    else                  y = x;
                end
                ACT_RELU: y = s1_gt0[k] ? x : ZERO_X;
`ifdef ACTIVATION_STREAM_LEAKY_RELU_EN
                ACT_LEAKY: y = s1_gt0[k] ? x : (x >>> 3);
`else
                ACT_LEAKY: y = x;
`endif
                default: y = x;
            endcase
            if (y > MAX_X)      y = MAX_X;
            else if (y < MIN_X) y = MIN_X;
            act_res[k*W +: W] = y[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= act_res;
            end
        end
    end

    // ---------------------------------------------------------------
    // Accepted-beat counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_count <= '0;
        end else if (count_clr) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_activation_stream.sv
// tb/tb_activation_stream.sv - directed self-checking bench for activation_stream

module tb_activation_stream;

    localparam int LANES = 4;
    localparam int W     = 16;
    localparam int FRAC  = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_act;
    logic [LANES*W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] out_data;
    logic               count_clr;
    logic [15:0]        out_count;

    int checks = 0;
    int errors = 0;

    activation_stream #(.LANES(LANES), .W(W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count_clr (count_clr),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // One beat through an idle pipeline with out_ready high: checks the
    // two-cycle latency and the activated value.
    task automatic run_beat(input string tag, input logic [2:0] act,
                            input logic [63:0] data, input logic [63:0] exp);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_act   = act;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_not_yet"}, out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, exp);
        @(negedge clk);
    endtask

    function automatic logic [63:0] beat_data(input int i);
        return {16'h8000 + 16'(i), 16'(i * 16), 16'h0100, 16'(i)};
    endfunction

    // ReLU of beat_data: lane 3 is negative and clips to zero.
    function automatic logic [63:0] beat_exp(input int i);
        return {16'h0000, 16'(i * 16), 16'h0100, 16'(i)};
    endfunction

    initial begin
        int   sent;
        int   rcvd;
        int   cyc;
        logic stalled_prev;
        logic [63:0] prev_data;
        logic saw_block;
        logic saw_stale;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_act    = 3'd0;
        in_data   = '0;
        out_ready = 1'b1;
        count_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_count", out_count, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;

        // Lane order written {lane3, lane2, lane1, lane0}.
        run_beat("sigmoid_a", 3'd1, {16'h0100, 16'hFE00, 16'h0200, 16'h0000},
                                    {16'h00C0, 16'h0000, 16'h0100, 16'h0080});
        run_beat("sigmoid_b", 3'd1, {16'h8000, 16'hFE01, 16'h01FF, 16'h7FFF},
                                    {16'h0000, 16'h0000, 16'h00FF, 16'h0100});
        run_beat("tanh", 3'd2, {16'h8000, 16'h0040, 16'hFE80, 16'h0180},
                               {16'hFF00, 16'h0040, 16'hFF00, 16'h0100});
        run_beat("step", 3'd0, {16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001},
                               {16'h0100, 16'h0000, 16'h0000, 16'h0100});
        run_beat("relu", 3'd3, {16'h0000, 16'h8000, 16'hFFFF, 16'h1234},
                               {16'h0000, 16'h0000, 16'h0000, 16'h1234});
        run_beat("ident", 3'd6, {16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234},
                                {16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234});
`ifdef ACTIVATION_STREAM_LEAKY_RELU_EN
        run_beat("code4", 3'd4, {16'h0100, 16'h8000, 16'hFFF8, 16'hFF00},
                                {16'h0100, 16'hF000, 16'hFFFF, 16'hFFE0});
`else
        run_beat("code4", 3'd4, {16'h0100, 16'h8000, 16'hFFF8, 16'hFF00},
                                {16'h0100, 16'h8000, 16'hFFF8, 16'hFF00});
`endif

        // Ten back-to-back ReLU beats with a downstream stall on cycles 3-6.
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        stalled_prev = 1'b0;
        prev_data    = '0;
        saw_block    = 1'b0;
        while (rcvd < 10 && cyc < 60) begin
            if (stalled_prev) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_data_hold", out_data, prev_data);
            end
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 10);
            in_act    = 3'd3;
            in_data   = beat_data(sent);
            #1;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                check("stream_order", out_data, beat_exp(rcvd));
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_all_received", 32'(rcvd), 32'd10);
        check("stream_in_ready_low", saw_block, 1'b1);
        check("stream_count", out_count, 16'd10);

        // Reset with both stages holding beats.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_act    = 3'd5;
        in_data   = 64'h1111_2222_3333_4444;
        @(negedge clk);
        in_data   = 64'h5555_6666_7777_8888;
        @(negedge clk);
        in_valid  = 1'b0;
        check("full_out_valid", out_valid, 1'b1);
        check("full_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 64'h0);
        check("midrst_count", out_count, 16'h0);
        check("midrst_in_ready", in_ready, 1'b1);
        saw_stale = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) saw_stale = 1'b1;
        end
        check("midrst_no_stale", saw_stale, 1'b0);

        // Counter wrap: 65535 streamed beats, then one more.
        in_valid = 1'b1;
        in_act   = 3'd7;
        in_data  = 64'h0;
        repeat (65535) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("count_ffff", out_count, 16'hFFFF);
        run_beat("wrap_beat", 3'd7, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001);
        check("count_wrap", out_count, 16'h0000);
        run_beat("post_wrap", 3'd7, 64'h0, 64'h0);
        check("count_one", out_count, 16'h0001);

        // count_clr coinciding with an accepted output beat.
        @(negedge clk);
        in_valid = 1'b1;
        in_act   = 3'd7;
        in_data  = 64'hABCD;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_beat_valid", out_valid, 1'b1);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        check("clr_priority", out_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/activation_stream.md
ACTIVATION_STREAM -- requirements
Module: activation_stream

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel fixed-point lanes (1..16).
REQ-002 SHALL have parameter W, default 16, signed lane width in bits (8..32).
REQ-003 SHALL have parameter FRAC, default 8, fractional bits per lane (1..W-2); ONE = 1<<FRAC.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_act  input  3  mode: 0 Step, 1 Sigmoid, 2 Tanh, 3 ReLU, 4 LeakyReLU, 5-7 identity.
REQ-009 SHALL have port in_data  input  LANES*W  lane k at bits [k*W +: W], two's complement.
REQ-010 SHALL have port out_valid  output  1  output beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 SHALL have port out_data  output  LANES*W  activated lanes, same packing.
REQ-013 SHALL have port count_clr  input  1  synchronous clear of out_count.
REQ-014 SHALL have port out_count  output  16  number of output beats accepted.

Function
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers in_data/in_act and per-lane region flags (x>0, x>=ONE, x<=-ONE, x>=2*ONE, x<=-2*ONE); stage 2 registers the activated result.
REQ-016 SHALL give latency 2 cycles from accepted input to out_valid with out_ready held 1, throughput 1 beat/cycle.
REQ-017 SHALL drive in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready; no combinational in_valid->in_ready path.
REQ-018 SHALL hold out_data and out_valid stable while out_valid && !out_ready; no beat dropped or duplicated.
REQ-019 SHALL apply Step: x>0 -> ONE, else 0.
REQ-020 SHALL apply Sigmoid as hard sigmoid: y = (x>>>2) + ONE/2, clamped to [0, ONE] (x>=2*ONE -> ONE, x<=-2*ONE -> 0).
REQ-021 SHALL apply Tanh as hard tanh: clamp x to [-ONE, ONE].
REQ-022 SHALL apply ReLU: x>0 -> x, else 0.
REQ-023 SHALL apply identity for codes 5-7 (and code 4 per REQ-030); one mode applies to all lanes of a beat.
REQ-024 SHALL compute all intermediates at W+2 bits and saturate results to W-bit signed range; no wrap.
REQ-025 SHALL increment out_count on each accepted output beat, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL give count_clr priority: count_clr with a simultaneous accepted beat yields out_count = 0.

Reset
REQ-027 SHALL, on reset, clear both stage valids, out_valid = 0, out_data = 0, out_count = 0, next cycle in_ready = 1.
REQ-028 SHALL discard in-flight beats on reset mid-operation; no output beat for them after reset.

Configuration
REQ-029 SHALL, with macro ACTIVATION_STREAM_LEAKY_RELU_EN defined, apply code 4 as LeakyReLU: x>0 -> x, else x>>>3 (arithmetic, floor).
REQ-030 SHALL, without ACTIVATION_STREAM_LEAKY_RELU_EN, treat code 4 as identity and instantiate no LeakyReLU logic.

Verification
REQ-031 SHALL pass: LANES=4,W=16,FRAC=8, Sigmoid, lanes {0x0000,0x0200,0xFE00,0x0100}, out_ready=1 -> 2 cycles later {0x0080,0x0100,0x0000,0x00C0}.
REQ-032 SHALL pass: Tanh lanes {0x0180,0xFE80,0x0040,0x8000} -> {0x0100,0xFF00,0x0040,0xFF00}; Step on {0x0001,0x0000} -> {0x0100,0x0000}.
REQ-033 SHALL pass: 10 back-to-back beats, out_ready low cycles 3-6 -> all 10 beats delivered in order, out_data stable while stalled, in_ready low once both stages full, out_count = 10.
REQ-034 SHALL pass: out_count preset to 0xFFFF via 65535 beats, one more beat -> 0x0000; count_clr with a beat -> 0.
REQ-035 SHALL pass: reset asserted with both stages full -> out_valid = 0 next cycle, stale beats never emitted, out_count = 0.
REQ-036 SHALL pass: code 4, lane 0xFF00 -> 0xFFE0 with ACTIVATION_STREAM_LEAKY_RELU_EN, 0xFF00 without.
